// File: rtl/ttl_decoder_scan_arbiter.sv
// Round-robin arbiter sharing one 74238-style 3-to-8 decoder among
// WIDTH_OUT requesters. The decoder select and enables come straight from
// flops. There is one dead cycle between grants, and an optional hold
// timeout revokes a grant that is held too long.
module ttl_decoder_scan_arbiter #(
    parameter int unsigned WIDTH_OUT  = 8,
    parameter int unsigned WIDTH_IN   = $clog2(WIDTH_OUT),
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned DELAY_RISE = 0,
    parameter int unsigned DELAY_FALL = 0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [WIDTH_OUT-1:0] Request,
    input  logic                 Release,
    output logic [WIDTH_IN-1:0]  A,
    output logic                 Enable1_bar,
    output logic                 Enable2_bar,
    output logic                 Enable3,
    output logic                 Busy,
    output logic                 Timeout
);

    // Hold counter runs 0 .. MAX_HOLD-1 during a grant.
    localparam int unsigned CNT_W     = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned HOLD_LAST = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
    localparam logic [CNT_W-1:0] HOLD_LAST_C = CNT_W'(HOLD_LAST);
    localparam bit HOLD_EN = (MAX_HOLD != 0);
    localparam logic [WIDTH_IN-1:0] LAST_RESET = WIDTH_IN'(WIDTH_OUT - 1);

    // Output delays belong to the board-level timing model. In synthesized
    // logic the registered outputs carry no extra delay.
    if ((DELAY_RISE != 0) || (DELAY_FALL != 0)) begin : g_delay_model_only
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH_IN-1:0]  a_q, a_d;
    logic [WIDTH_IN-1:0]  last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 en1_bar_q, en1_bar_d;
    logic                 en2_bar_q, en2_bar_d;
    logic                 en3_q, en3_d;
    logic                 timeout_q, timeout_d;

    logic                 pick_valid;
    logic [WIDTH_IN-1:0]  pick_idx;
    logic [WIDTH_IN-1:0]  cand;
    logic                 rel_exit;
    logic                 hold_exit;

    // Round-robin pick: first requester after last_q, wrapping at WIDTH_OUT.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= WIDTH_OUT; k++) begin
            cand = WIDTH_IN'((32'(last_q) + k) % WIDTH_OUT);
            if (!pick_valid && Request[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/GRANT/GAP controller.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        en1_bar_d = en1_bar_q;
        en2_bar_d = en2_bar_q;
        en3_d     = en3_q;
        timeout_d = 1'b0;
        rel_exit  = 1'b0;
        hold_exit = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (pick_valid) begin
                    state_d   = ST_GRANT;
                    a_d       = pick_idx;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    en1_bar_d = 1'b0;
                    en2_bar_d = 1'b0;
                    en3_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                rel_exit  = Release || !Request[a_q];
                hold_exit = HOLD_EN && (cnt_q == HOLD_LAST_C);
                if (rel_exit || hold_exit) begin
                    state_d   = ST_GAP;
                    last_d    = a_q;
                    busy_d    = 1'b0;
                    en1_bar_d = 1'b1;
                    en2_bar_d = 1'b1;
                    en3_d     = 1'b0;
                    // A revocation counts as a timeout only if the grantee
                    // was not already giving up the grant on this edge.
                    timeout_d = hold_exit && !rel_exit;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            last_q    <= LAST_RESET;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            en1_bar_q <= 1'b1;
            en2_bar_q <= 1'b1;
            en3_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            en1_bar_q <= en1_bar_d;
            en2_bar_q <= en2_bar_d;
            en3_q     <= en3_d;
            timeout_q <= timeout_d;
        end
    end

    assign A           = a_q;
    assign Enable1_bar = en1_bar_q;
    assign Enable2_bar = en2_bar_q;
    assign Enable3     = en3_q;
    assign Busy        = busy_q;
    assign Timeout     = timeout_q;

endmodule

// File: tb/tb_ttl_decoder_scan_arbiter.sv
// Scoreboard bench for ttl_decoder_scan_arbiter. The stimulus pushes the
// expected grant-start and grant-end events. A monitor watches Busy edges
// and compares each event against the queue.
module tb_ttl_decoder_scan_arbiter;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] Request = 8'h00;
    logic       Release = 1'b0;
    logic [2:0] A;
    logic       Enable1_bar, Enable2_bar, Enable3, Busy, Timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit is_end;  // 0: grant start, 1: grant end
        int val;     // grant start: index; grant end: held cycles
        int gap;     // grant start: dead cycles before it, -1 = don't care
        bit to;      // grant end: Timeout expected in the following cycle
    } ev_t;

    ev_t exp_q[$];

    ttl_decoder_scan_arbiter #(
        .WIDTH_OUT(8),
        .MAX_HOLD (4)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Request    (Request),
        .Release    (Release),
        .A          (A),
        .Enable1_bar(Enable1_bar),
        .Enable2_bar(Enable2_bar),
        .Enable3    (Enable3),
        .Busy       (Busy),
        .Timeout    (Timeout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_gnt(input int idx, input int gap);
        ev_t e;
        e.is_end = 1'b0; e.val = idx; e.gap = gap; e.to = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_end(input int len, input bit to);
        ev_t e;
        e.is_end = 1'b1; e.val = len; e.gap = -1; e.to = to;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_A"}, A, 0);
        chk({tag, "_En1b"}, Enable1_bar, 1);
        chk({tag, "_En2b"}, Enable2_bar, 1);
        chk({tag, "_En3"}, Enable3, 0);
        chk({tag, "_Busy"}, Busy, 0);
        chk({tag, "_Timeout"}, Timeout, 0);
    endtask

    // Two reset edges; outputs are checked right after the first one.
    task automatic do_reset(input string tag);
        Reset = 1'b1;
        tick();
        check_reset_values(tag);
        tick();
        Reset = 1'b0;
    endtask

    // Monitor: detects grant starts/ends on Busy and scores them.
    int  mon_len = 0;
    int  mon_gap = -1;
    bit  mon_prev = 1'b0;
    always @(negedge Clk) begin
        ev_t e;
        if (Reset) begin
            mon_prev = 1'b0;
            mon_len  = 0;
            mon_gap  = -1;
        end else begin
            if (Busy && !mon_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", int'(A), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind_start", 0, int'(e.is_end));
                    chk("grant_A", A, e.val);
                    if (e.gap >= 0) chk("dead_cycles", mon_gap, e.gap);
                    chk("grant_En1b", Enable1_bar, 0);
                    chk("grant_En2b", Enable2_bar, 0);
                    chk("grant_En3", Enable3, 1);
                    chk("grant_Timeout", Timeout, 0);
                end
                mon_len = 1;
            end else if (Busy) begin
                mon_len++;
                chk("hold_Timeout", Timeout, 0);
            end else if (mon_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_release", mon_len, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind_end", 1, int'(e.is_end));
                    chk("hold_len", mon_len, e.val);
                    chk("gap_Timeout", Timeout, int'(e.to));
                    chk("gap_En1b", Enable1_bar, 1);
                    chk("gap_En2b", Enable2_bar, 1);
                    chk("gap_En3", Enable3, 0);
                end
                mon_gap = 1;
            end else begin
                if (mon_gap >= 0) mon_gap++;
                chk("idle_Timeout", Timeout, 0);
            end
            mon_prev = Busy;
        end
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, then single requester 2.
        do_reset("rst0");
        Request = 8'b0000_0100;
        push_gnt(2, -1);
        push_end(1, 1'b0);
        tick();                         // grant 2
        Release = 1'b1;
        tick();                         // release -> GAP
        Release = 1'b0;
        Request = 8'h00;
        tick();                         // GAP -> IDLE
        tick();

        // All requesting, one-cycle grants: 0..7 then 0, one dead cycle each.
        do_reset("rst1");
        Request = 8'hFF;
        push_gnt(0, -1);
        tick();                         // grant 0
        for (int g = 0; g <= 8; g++) begin
            push_end(1, 1'b0);
            if (g < 8) push_gnt((g + 1) % 8, 1);
            Release = 1'b1;
            tick();                     // exit
            Release = 1'b0;
            if (g == 8) Request = 8'h00;
            tick();                     // regrant or idle
        end
        tick();

        // Hold timeout on sole requester 4, then re-grant after the GAP.
        Request = 8'h10;
        push_gnt(4, -1);
        push_end(4, 1'b1);
        push_gnt(4, 1);
        push_end(1, 1'b0);
        repeat (6) tick();              // grant, 3 holds, timeout exit, regrant
        Release = 1'b1;
        tick();
        Release = 1'b0;
        Request = 8'h00;
        tick();
        tick();

        // Release coincident with the hold limit: no Timeout pulse.
        Request = 8'h10;
        push_gnt(4, -1);
        push_end(4, 1'b0);
        repeat (4) tick();
        Release = 1'b1;
        tick();
        Release = 1'b0;
        Request = 8'h00;
        tick();
        tick();

        // Wrap: after 6 ends, {6,0} requesting grants 0 then 6.
        Request = 8'h40;
        push_gnt(6, -1);
        push_end(1, 1'b0);
        push_gnt(0, 1);
        push_end(1, 1'b0);
        push_gnt(6, 1);
        push_end(1, 1'b0);
        tick();                         // grant 6
        Release = 1'b1;
        Request = 8'b0100_0001;
        tick();                         // exit 6
        Release = 1'b0;
        tick();                         // grant 0
        Release = 1'b1;
        tick();                         // exit 0
        Release = 1'b0;
        tick();                         // grant 6
        Release = 1'b1;
        tick();                         // exit 6
        Release = 1'b0;
        Request = 8'h00;
        tick();
        tick();

        // Reset mid-grant on 3, then grant 7.
        Request = 8'h08;
        push_gnt(3, -1);
        tick();                         // grant 3
        tick();
        do_reset("rst_mid");
        Request = 8'h80;
        push_gnt(7, -1);
        push_end(1, 1'b0);
        tick();                         // grant 7
        Release = 1'b1;
        tick();
        Release = 1'b0;
        Request = 8'h00;
        tick();
        tick();

        // Request[5] drops before the hold limit: exit without Timeout.
        Request = 8'h20;
        push_gnt(5, -1);
        push_end(2, 1'b0);
        tick();                         // grant 5
        tick();
        Request = 8'h00;
        tick();                         // exit on dropped request
        tick();
        tick();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("events_outstanding", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
